// File: rtl/core_issue_ctrl_pkg.sv
// Shared encodings for the issue controller: opcodes, writeback classes,
// FSM state encodings and register-use decode helpers.
package core_issue_ctrl_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPCODE_I_LOAD = 7'b0000011;
  localparam logic [6:0] OPCODE_S      = 7'b0100011;
  localparam logic [6:0] OPCODE_B      = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [3:0] WB_CODE_NONE = 4'd0;
  localparam logic [3:0] WB_CODE_ALU  = 4'd1;
  localparam logic [3:0] WB_CODE_LOAD = 4'd2;
  localparam logic [3:0] WB_CODE_PC   = 4'd3;

  localparam logic ISSUE_S_ISSUE   = 1'b0;
  localparam logic ISSUE_S_CF_WAIT = 1'b1;

  typedef enum logic {
    S_ISSUE   = ISSUE_S_ISSUE,
    S_CF_WAIT = ISSUE_S_CF_WAIT
  } issue_state_t;

  // Returns {uses_rs2, uses_rs1}; unknown opcodes read no registers.
  function automatic logic [1:0] src_use(input logic [6:0] op);
    case (op)
      OPCODE_R, OPCODE_S, OPCODE_B:             src_use = 2'b11;
      OPCODE_I_ALU, OPCODE_I_LOAD, OPCODE_JALR: src_use = 2'b01;
      default:                                  src_use = 2'b00;
    endcase
  endfunction

  function automatic logic is_cf(input logic [6:0] op);
    is_cf = (op == OPCODE_B) || (op == OPCODE_JAL) || (op == OPCODE_JALR);
  endfunction

endpackage

// File: rtl/core_issue_ctrl_scoreboard.sv
// Register busy scoreboard: per-register pending-write bits, outstanding
// write counter and a sticky error for retiring a register that is not busy.
module core_scoreboard
  #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [4:0]       set_addr,
    input  logic             clr_en,
    input  logic [4:0]       clr_addr,
    input  logic [4:0]       look_addr1,
    input  logic [4:0]       look_addr2,
    input  logic [4:0]       look_addr3,
    output logic             busy1,
    output logic             busy2,
    output logic             busy3,
    output logic [CNT_W-1:0] cnt,
    output logic             err
  );

  logic [31:0]      busy_reg;
  logic [31:0]      busy_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  logic             set_ok;
  logic             clr_ok;
  logic             clr_bad;

  assign set_ok  = set_en && (set_addr != 5'd0);
  assign clr_ok  = clr_en && (clr_addr != 5'd0) && busy_reg[clr_addr];
  assign clr_bad = clr_en && (clr_addr != 5'd0) && !busy_reg[clr_addr];

  // Set wins over a clear of the same bit in the same cycle.
  for (genvar gi = 0; gi < 32; gi++) begin : g_busy
    assign busy_next[gi] = (set_ok && (set_addr == 5'(gi))) ||
                           (busy_reg[gi] && !(clr_ok && (clr_addr == 5'(gi))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      if (set_ok && !clr_ok)
        cnt_reg <= cnt_reg + CNT_W'(1);
      else if (clr_ok && !set_ok)
        cnt_reg <= cnt_reg - CNT_W'(1);
      if (clr_bad)
        err_reg <= 1'b1;
    end
  end

  assign busy1 = busy_reg[look_addr1];
  assign busy2 = busy_reg[look_addr2];
  assign busy3 = busy_reg[look_addr3];
  assign cnt   = cnt_reg;
  assign err   = err_reg;

endmodule

// File: rtl/core_issue_ctrl.sv
// Issue controller: hazard-gated valid/ready acceptance from decode into a
// one-entry registered slot toward execute, with control-flow stall state.
module core_issue_ctrl
  import core_issue_ctrl_pkg::*;
  #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
  )
  (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       ID_VALID,
    output logic       ID_READY,
    input  logic [6:0] ID_OPCODE,
    input  logic [4:0] ID_ARADDR1,
    input  logic [4:0] ID_ARADDR2,
    input  logic [4:0] ID_AWADDR,
    input  logic       ID_AWVALID,
    input  logic [3:0] ID_WB_CODE,
    output logic       EX_VALID,
    input  logic       EX_READY,
    output logic [6:0] EX_OPCODE,
    output logic [4:0] EX_AWADDR,
    output logic       EX_AWVALID,
    output logic [3:0] EX_WB_CODE,
    input  logic       WB_VALID,
    input  logic [4:0] WB_AWADDR,
    input  logic       CF_RESOLVE,
    input  logic       FLUSH,
    output logic       SB_ERR
  );

  issue_state_t     state_reg, state_next;
  logic             ex_valid_reg;
  logic [6:0]       ex_opcode_reg;
  logic [4:0]       ex_awaddr_reg;
  logic             ex_awvalid_reg;
  logic [3:0]       ex_wb_code_reg;
  logic [1:0]       use_src;
  logic             busy_rs1, busy_rs2, busy_rd;
  logic [CNT_W-1:0] sb_cnt;
  logic             haz_rs1, haz_rs2, waw;
  logic             issue, handoff;

  assign use_src = src_use(ID_OPCODE);

  // A retire in the same cycle bypasses the source busy bit, never the slot.
  assign haz_rs1 = use_src[0] && (ID_ARADDR1 != 5'd0) &&
                   ((busy_rs1 && !(WB_VALID && WB_AWADDR == ID_ARADDR1)) ||
                    (ex_valid_reg && ex_awvalid_reg && ex_awaddr_reg == ID_ARADDR1));
  assign haz_rs2 = use_src[1] && (ID_ARADDR2 != 5'd0) &&
                   ((busy_rs2 && !(WB_VALID && WB_AWADDR == ID_ARADDR2)) ||
                    (ex_valid_reg && ex_awvalid_reg && ex_awaddr_reg == ID_ARADDR2));
  assign waw     = ID_AWVALID && (ID_AWADDR != 5'd0) &&
                   (busy_rd || (ex_valid_reg && ex_awvalid_reg && ex_awaddr_reg == ID_AWADDR));

  assign ID_READY = NRST && (state_reg == S_ISSUE) && !FLUSH && !haz_rs1 && !haz_rs2 &&
                    !waw && (sb_cnt < CNT_W'(MAX_OUTSTANDING)) &&
                    (!ex_valid_reg || EX_READY);
  assign issue    = ID_VALID && ID_READY;
  assign handoff  = ex_valid_reg && EX_READY && !FLUSH;

  core_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_sb (
    .clk       (CLK),
    .rst_n     (NRST),
    .set_en    (handoff && ex_awvalid_reg),
    .set_addr  (ex_awaddr_reg),
    .clr_en    (WB_VALID),
    .clr_addr  (WB_AWADDR),
    .look_addr1(ID_ARADDR1),
    .look_addr2(ID_ARADDR2),
    .look_addr3(ID_AWADDR),
    .busy1     (busy_rs1),
    .busy2     (busy_rs2),
    .busy3     (busy_rd),
    .cnt       (sb_cnt),
    .err       (SB_ERR)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_reg      <= S_ISSUE;
      ex_valid_reg   <= 1'b0;
      ex_opcode_reg  <= '0;
      ex_awaddr_reg  <= '0;
      ex_awvalid_reg <= 1'b0;
      ex_wb_code_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (FLUSH) begin
        ex_valid_reg <= 1'b0;
      end else if (issue) begin
        ex_valid_reg   <= 1'b1;
        ex_opcode_reg  <= ID_OPCODE;
        ex_awaddr_reg  <= ID_AWADDR;
        ex_awvalid_reg <= ID_AWVALID;
        ex_wb_code_reg <= ID_WB_CODE;
      end else if (handoff) begin
        ex_valid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (FLUSH) begin
      state_next = S_ISSUE;
    end else begin
      case (state_reg)
        S_ISSUE:   if (issue && is_cf(ID_OPCODE)) state_next = S_CF_WAIT;
        S_CF_WAIT: if (CF_RESOLVE) state_next = S_ISSUE;
        default:   state_next = S_ISSUE;
      endcase
    end
  end

  assign EX_VALID   = ex_valid_reg;
  assign EX_OPCODE  = ex_opcode_reg;
  assign EX_AWADDR  = ex_awaddr_reg;
  assign EX_AWVALID = ex_awvalid_reg;
  assign EX_WB_CODE = ex_wb_code_reg;

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl: hand-computed expectations for reset,
// hazards, outstanding limit, control-flow stall, flush and scoreboard error.
module tb_core_issue_ctrl;
  import core_issue_ctrl_pkg::*;

  logic       CLK, NRST;
  logic       ID_VALID, ID_READY, ID_AWVALID;
  logic [6:0] ID_OPCODE;
  logic [4:0] ID_ARADDR1, ID_ARADDR2, ID_AWADDR;
  logic [3:0] ID_WB_CODE;
  logic       EX_VALID, EX_READY, EX_AWVALID;
  logic [6:0] EX_OPCODE;
  logic [4:0] EX_AWADDR;
  logic [3:0] EX_WB_CODE;
  logic       WB_VALID;
  logic [4:0] WB_AWADDR;
  logic       CF_RESOLVE, FLUSH, SB_ERR;

  int checks = 0;
  int errors = 0;

  core_issue_ctrl #(.MAX_OUTSTANDING(4)) dut (
    .CLK(CLK), .NRST(NRST),
    .ID_VALID(ID_VALID), .ID_READY(ID_READY), .ID_OPCODE(ID_OPCODE),
    .ID_ARADDR1(ID_ARADDR1), .ID_ARADDR2(ID_ARADDR2), .ID_AWADDR(ID_AWADDR),
    .ID_AWVALID(ID_AWVALID), .ID_WB_CODE(ID_WB_CODE),
    .EX_VALID(EX_VALID), .EX_READY(EX_READY), .EX_OPCODE(EX_OPCODE),
    .EX_AWADDR(EX_AWADDR), .EX_AWVALID(EX_AWVALID), .EX_WB_CODE(EX_WB_CODE),
    .WB_VALID(WB_VALID), .WB_AWADDR(WB_AWADDR),
    .CF_RESOLVE(CF_RESOLVE), .FLUSH(FLUSH), .SB_ERR(SB_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s value=%0h t=%0t", tag, obs, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_id(input logic vld, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic awv,
                        input logic [3:0] wb);
    ID_VALID   = vld;
    ID_OPCODE  = op;
    ID_ARADDR1 = rs1;
    ID_ARADDR2 = rs2;
    ID_AWADDR  = rd;
    ID_AWVALID = awv;
    ID_WB_CODE = wb;
    #1;
  endtask

  task automatic retire(input logic [4:0] rd);
    WB_VALID  = 1'b1;
    WB_AWADDR = rd;
    tick();
    WB_VALID  = 1'b0;
    WB_AWADDR = 5'd0;
    #1;
  endtask

  initial begin
    NRST = 1'b0; EX_READY = 1'b0; WB_VALID = 1'b0; WB_AWADDR = 5'd0;
    CF_RESOLVE = 1'b0; FLUSH = 1'b0;
    set_id(1'b1, OPCODE_R, 5'd2, 5'd3, 5'd1, 1'b1, WB_CODE_ALU);
    check_eq("rst_ready", ID_READY, 0);
    check_eq("rst_ex_valid", EX_VALID, 0);
    check_eq("rst_sb_err", SB_ERR, 0);
    @(negedge CLK); @(negedge CLK);
    NRST = 1'b1; #1;

    // ADD x1,x2,x3: accepted now, visible in the slot one edge later
    check_eq("add_ready", ID_READY, 1);
    tick();
    set_id(1'b0, OPCODE_R, 5'd2, 5'd3, 5'd1, 1'b1, WB_CODE_ALU);
    check_eq("add_ex_valid", EX_VALID, 1);
    check_eq("add_ex_op", EX_OPCODE, OPCODE_R);
    check_eq("add_ex_rd", EX_AWADDR, 1);
    check_eq("add_ex_wb", EX_WB_CODE, WB_CODE_ALU);
    check_eq("slot_full_ready", ID_READY, 0);
    EX_READY = 1'b1;
    tick();
    check_eq("add_handoff", EX_VALID, 0);
    check_eq("add_cnt", dut.sb_cnt, 1);
    retire(5'd1);
    check_eq("add_retire_cnt", dut.sb_cnt, 0);

    // RAW on x5 with writeback bypass
    set_id(1'b1, OPCODE_I_ALU, 5'd0, 5'd0, 5'd5, 1'b1, WB_CODE_ALU);
    tick();
    set_id(1'b0, OPCODE_I_ALU, 5'd0, 5'd0, 5'd5, 1'b1, WB_CODE_ALU);
    tick();
    set_id(1'b1, OPCODE_R, 5'd5, 5'd0, 5'd6, 1'b1, WB_CODE_ALU);
    check_eq("raw_stall0", ID_READY, 0);
    tick();
    check_eq("raw_stall1", ID_READY, 0);
    WB_VALID = 1'b1; WB_AWADDR = 5'd5; #1;
    check_eq("raw_bypass", ID_READY, 1);
    tick();
    WB_VALID = 1'b0; WB_AWADDR = 5'd0;
    set_id(1'b1, OPCODE_R, 5'd6, 5'd0, 5'd7, 1'b1, WB_CODE_ALU);
    check_eq("raw_issued_rd", EX_AWADDR, 6);
    check_eq("slot_raw_stall", ID_READY, 0);
    set_id(1'b0, OPCODE_R, 5'd6, 5'd0, 5'd7, 1'b1, WB_CODE_ALU);
    tick();
    // WAW on busy x6 is not lifted by a same-cycle retire of x6
    set_id(1'b1, OPCODE_LUI, 5'd0, 5'd0, 5'd6, 1'b1, WB_CODE_ALU);
    WB_VALID = 1'b1; WB_AWADDR = 5'd6; #1;
    check_eq("waw_stall", ID_READY, 0);
    ID_VALID = 1'b0;
    tick();
    WB_VALID = 1'b0; WB_AWADDR = 5'd0; #1;
    check_eq("waw_cnt", dut.sb_cnt, 0);

    // Outstanding limit of four
    for (int i = 1; i <= 4; i++) begin
      set_id(1'b1, OPCODE_I_LOAD, 5'd0, 5'd0, 5'(i), 1'b1, WB_CODE_LOAD);
      tick();
    end
    set_id(1'b0, OPCODE_I_LOAD, 5'd0, 5'd0, 5'd5, 1'b1, WB_CODE_LOAD);
    tick();
    check_eq("lim_cnt4", dut.sb_cnt, 4);
    set_id(1'b1, OPCODE_I_LOAD, 5'd0, 5'd0, 5'd5, 1'b1, WB_CODE_LOAD);
    check_eq("lim_stall0", ID_READY, 0);
    tick();
    check_eq("lim_stall1", ID_READY, 0);
    WB_VALID = 1'b1; WB_AWADDR = 5'd1; #1;
    check_eq("lim_retire_cycle", ID_READY, 0);
    tick();
    WB_VALID = 1'b0; WB_AWADDR = 5'd0; #1;
    check_eq("lim_ready", ID_READY, 1);
    tick();
    ID_VALID = 1'b0;
    tick();
    check_eq("lim_cnt_back", dut.sb_cnt, 4);
    for (int i = 2; i <= 5; i++) retire(5'(i));
    check_eq("lim_cnt_zero", dut.sb_cnt, 0);

    // BEQ waits for resolution
    set_id(1'b1, OPCODE_B, 5'd0, 5'd0, 5'd0, 1'b0, WB_CODE_NONE);
    tick();
    set_id(1'b1, OPCODE_R, 5'd2, 5'd3, 5'd1, 1'b1, WB_CODE_ALU);
    for (int i = 0; i < 3; i++) begin
      check_eq("cf_wait", ID_READY, 0);
      tick();
    end
    CF_RESOLVE = 1'b1; #1;
    check_eq("cf_resolve_cycle", ID_READY, 0);
    tick();
    CF_RESOLVE = 1'b0; #1;
    check_eq("cf_resolved", ID_READY, 1);
    tick();
    ID_VALID = 1'b0;
    check_eq("cf_next_op", EX_OPCODE, OPCODE_R);
    tick();
    retire(5'd1);

    // FLUSH with an occupied slot (JAL x7) while waiting on control flow
    EX_READY = 1'b0;
    set_id(1'b1, OPCODE_JAL, 5'd0, 5'd0, 5'd7, 1'b1, WB_CODE_PC);
    tick();
    ID_VALID = 1'b0; #1;
    check_eq("jal_slot", EX_VALID, 1);
    EX_READY = 1'b1; FLUSH = 1'b1; #1;
    check_eq("flush_ready", ID_READY, 0);
    tick();
    FLUSH = 1'b0;
    set_id(1'b1, OPCODE_LUI, 5'd0, 5'd0, 5'd7, 1'b1, WB_CODE_ALU);
    check_eq("flush_ex_valid", EX_VALID, 0);
    check_eq("flush_cnt", dut.sb_cnt, 0);
    check_eq("flush_state_no_busy7", ID_READY, 1);
    ID_VALID = 1'b0; #1;

    // Retire to x0 is ignored; retire of non-busy x9 sets sticky error
    retire(5'd0);
    check_eq("x0_retire_err", SB_ERR, 0);
    retire(5'd9);
    check_eq("err_set", SB_ERR, 1);
    tick(); tick();
    check_eq("err_sticky", SB_ERR, 1);

    // Asynchronous reset with busy x5 and an occupied slot
    set_id(1'b1, OPCODE_I_ALU, 5'd0, 5'd0, 5'd5, 1'b1, WB_CODE_ALU);
    tick();
    ID_VALID = 1'b0;
    tick();
    EX_READY = 1'b0;
    set_id(1'b1, OPCODE_I_ALU, 5'd0, 5'd0, 5'd8, 1'b1, WB_CODE_ALU);
    tick();
    check_eq("pre_rst_slot", EX_VALID, 1);
    #1 NRST = 1'b0; #1;
    check_eq("arst_ex_valid", EX_VALID, 0);
    check_eq("arst_ex_op", EX_OPCODE, 0);
    check_eq("arst_ex_rd", EX_AWADDR, 0);
    check_eq("arst_ex_awv", EX_AWVALID, 0);
    check_eq("arst_sb_err", SB_ERR, 0);
    check_eq("arst_ready", ID_READY, 0);
    @(negedge CLK);
    NRST = 1'b1; EX_READY = 1'b1;
    set_id(1'b1, OPCODE_R, 5'd5, 5'd3, 5'd1, 1'b1, WB_CODE_ALU);
    check_eq("post_rst_ready", ID_READY, 1);
    tick();
    ID_VALID = 1'b0; #1;
    check_eq("post_rst_issue", EX_AWADDR, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=0 expected=1");
    $fatal(1, "timeout");
  end

endmodule
